// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access: turns EX/MEM control into a req/ack transaction and registers MEM/WB.
// Latency: non-memory ops 1 cycle; memory ops 1 accept cycle + BUSY cycles until ack (minimum 2).
// Backpressure: o_stall holds the pipeline while a transaction is outstanding; i_step freezes acceptance in IDLE only.
module mem_access_unit #(
    parameter int NB_DATA = 32,
    parameter int NB_REG  = 5
) (
    input  logic               clk,
    input  logic               i_reset,
    input  logic               i_step,
    input  logic               i_mem2reg,
    input  logic               i_memWrite,
    input  logic               i_regWrite,
    input  logic [1:0]         i_width,
    input  logic               i_sign_flag,
    input  logic [NB_DATA-1:0] i_result,
    input  logic [NB_DATA-1:0] i_data4Mem,
    input  logic [NB_REG-1:0]  i_write_reg,
    output logic               o_stall,
    output logic               o_misaligned,
    output logic               o_dmem_req,
    output logic               o_dmem_we,
    output logic [NB_DATA-1:0] o_dmem_addr,
    output logic [3:0]         o_dmem_be,
    output logic [NB_DATA-1:0] o_dmem_wdata,
    input  logic [NB_DATA-1:0] i_dmem_rdata,
    input  logic               i_dmem_ack,
    output logic               o_regWrite,
    output logic               o_mem2reg,
    output logic [NB_DATA-1:0] o_wb_data,
    output logic [NB_REG-1:0]  o_write_reg
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state;
    logic [1:0]          addr_lo_q;
    logic [1:0]          width_q;
    logic                sign_q;
    logic                load_q;
    logic                regwrite_q;
    logic [NB_REG-1:0]   write_reg_q;

    logic                mem_op;
    logic                misaligned;
    logic                accept;
    logic [3:0]          be_c;
    logic [NB_DATA-1:0]  wdata_c;
    logic [NB_DATA-1:0]  lane;
    logic [NB_DATA-1:0]  load_c;

    // Decode the incoming entry: alignment check, byte enables and lane-replicated store data.
    always_comb begin
        mem_op     = i_mem2reg | i_memWrite;
        misaligned = 1'b0;
        be_c       = 4'b1111;
        wdata_c    = i_data4Mem;
        case (i_width)
            2'b00: begin
                be_c    = 4'b0001 << i_result[1:0];
                wdata_c = {4{i_data4Mem[7:0]}};
            end
            2'b01: begin
                misaligned = i_result[0];
                be_c       = i_result[1] ? 4'b1100 : 4'b0011;
                wdata_c    = {2{i_data4Mem[15:0]}};
            end
            default: begin
                misaligned = |i_result[1:0];
            end
        endcase
        accept  = (state == IDLE) && !i_step && mem_op && !misaligned;
        // Stall is combinational so the upstream register holds in the very cycle an op is taken.
        o_stall = i_reset & (accept | ((state == BUSY) & ~i_dmem_ack));
    end

    // Align and extend returned load data using the offset/width latched at acceptance.
    always_comb begin
        lane   = i_dmem_rdata >> {addr_lo_q, 3'b000};
        load_c = i_dmem_rdata;
        case (width_q)
            2'b00:   load_c = sign_q ? {{24{lane[7]}}, lane[7:0]}   : {24'b0, lane[7:0]};
            2'b01:   load_c = sign_q ? {{16{lane[15]}}, lane[15:0]} : {16'b0, lane[15:0]};
            default: load_c = i_dmem_rdata;
        endcase
    end

    // Transaction FSM with registered memory-port and MEM/WB outputs.
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            state        <= IDLE;
            addr_lo_q    <= '0;
            width_q      <= '0;
            sign_q       <= 1'b0;
            load_q       <= 1'b0;
            regwrite_q   <= 1'b0;
            write_reg_q  <= '0;
            o_misaligned <= 1'b0;
            o_dmem_req   <= 1'b0;
            o_dmem_we    <= 1'b0;
            o_dmem_addr  <= '0;
            o_dmem_be    <= '0;
            o_dmem_wdata <= '0;
            o_regWrite   <= 1'b0;
            o_mem2reg    <= 1'b0;
            o_wb_data    <= '0;
            o_write_reg  <= '0;
        end else begin
            o_misaligned <= 1'b0;
            case (state)
                IDLE: begin
                    if (!i_step) begin
                        if (!mem_op) begin
                            o_regWrite  <= i_regWrite;
                            o_mem2reg   <= 1'b0;
                            o_wb_data   <= i_result;
                            o_write_reg <= i_write_reg;
                        end else if (misaligned) begin
                            // Dropped access: bubble into MEM/WB, flag it for one cycle.
                            o_misaligned <= 1'b1;
                            o_regWrite   <= 1'b0;
                            o_mem2reg    <= 1'b0;
                        end else begin
                            state        <= BUSY;
                            addr_lo_q    <= i_result[1:0];
                            width_q      <= i_width;
                            sign_q       <= i_sign_flag;
                            load_q       <= i_mem2reg;
                            regwrite_q   <= i_regWrite;
                            write_reg_q  <= i_write_reg;
                            o_dmem_req   <= 1'b1;
                            o_dmem_we    <= i_memWrite;
                            o_dmem_addr  <= {i_result[NB_DATA-1:2], 2'b00};
                            o_dmem_be    <= be_c;
                            o_dmem_wdata <= wdata_c;
                            o_regWrite   <= 1'b0;
                            o_mem2reg    <= 1'b0;
                        end
                    end
                end
                BUSY: begin
                    // i_step is deliberately ignored here: an issued transaction always retires.
                    if (i_dmem_ack) begin
                        state       <= IDLE;
                        o_dmem_req  <= 1'b0;
                        o_regWrite  <= regwrite_q;
                        o_mem2reg   <= load_q;
                        o_wb_data   <= load_q ? load_c : '0;
                        o_write_reg <= write_reg_q;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: stimulus pushes expected events, a negedge monitor pops and compares.
// Inputs are driven #1 after posedge; outputs are sampled a further #1 later or at negedge.
// Memory responder is the stimulus itself (ack timing is directed per test).
module tb_mem_access_unit;

    logic        clk;
    logic        i_reset;
    logic        i_step;
    logic        i_mem2reg;
    logic        i_memWrite;
    logic        i_regWrite;
    logic [1:0]  i_width;
    logic        i_sign_flag;
    logic [31:0] i_result;
    logic [31:0] i_data4Mem;
    logic [4:0]  i_write_reg;
    logic        o_stall;
    logic        o_misaligned;
    logic        o_dmem_req;
    logic        o_dmem_we;
    logic [31:0] o_dmem_addr;
    logic [3:0]  o_dmem_be;
    logic [31:0] o_dmem_wdata;
    logic [31:0] i_dmem_rdata;
    logic        i_dmem_ack;
    logic        o_regWrite;
    logic        o_mem2reg;
    logic [31:0] o_wb_data;
    logic [4:0]  o_write_reg;

    mem_access_unit #(.NB_DATA(32), .NB_REG(5)) dut (
        .clk          (clk),
        .i_reset      (i_reset),
        .i_step       (i_step),
        .i_mem2reg    (i_mem2reg),
        .i_memWrite   (i_memWrite),
        .i_regWrite   (i_regWrite),
        .i_width      (i_width),
        .i_sign_flag  (i_sign_flag),
        .i_result     (i_result),
        .i_data4Mem   (i_data4Mem),
        .i_write_reg  (i_write_reg),
        .o_stall      (o_stall),
        .o_misaligned (o_misaligned),
        .o_dmem_req   (o_dmem_req),
        .o_dmem_we    (o_dmem_we),
        .o_dmem_addr  (o_dmem_addr),
        .o_dmem_be    (o_dmem_be),
        .o_dmem_wdata (o_dmem_wdata),
        .i_dmem_rdata (i_dmem_rdata),
        .i_dmem_ack   (i_dmem_ack),
        .o_regWrite   (o_regWrite),
        .o_mem2reg    (o_mem2reg),
        .o_wb_data    (o_wb_data),
        .o_write_reg  (o_write_reg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int K_REQ = 0;
    localparam int K_WB  = 1;
    localparam int K_MIS = 2;

    typedef struct {
        int          kind;
        logic [31:0] f0;
        logic [31:0] f1;
        logic [31:0] f2;
        logic [31:0] f3;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    logic prev_req = 1'b0;
    logic pend_wb  = 1'b0;
    int   stalls;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic push(input int k, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic [31:0] d);
        exp_t e;
        e.kind = k; e.f0 = a; e.f1 = b; e.f2 = c; e.f3 = d;
        sb.push_back(e);
    endtask

    task automatic pop_check(input int k, input string nm, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] c, input logic [31:0] d);
        exp_t e;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s: unexpected event kind %0d, scoreboard empty", nm, k);
        end else begin
            e = sb.pop_front();
            chk({nm, "_kind"}, k, e.kind);
            chk({nm, "_f0"}, a, e.f0);
            chk({nm, "_f1"}, b, e.f1);
            chk({nm, "_f2"}, c, e.f2);
            chk({nm, "_f3"}, d, e.f3);
        end
    endtask

    // Monitor: request issue, writeback after a completed handshake, misaligned pulse.
    always @(negedge clk) begin
        if (pend_wb)
            pop_check(K_WB, "wb", {31'b0, o_regWrite}, {31'b0, o_mem2reg}, o_wb_data, {27'b0, o_write_reg});
        pend_wb = i_reset && o_dmem_req && i_dmem_ack;
        if (o_dmem_req && !prev_req)
            pop_check(K_REQ, "req", o_dmem_addr, {28'b0, o_dmem_be}, {31'b0, o_dmem_we}, o_dmem_wdata);
        prev_req = o_dmem_req;
        if (o_misaligned)
            pop_check(K_MIS, "mis", {31'b0, o_dmem_req}, {31'b0, o_regWrite}, {31'b0, o_mem2reg}, {31'b0, o_stall});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        i_mem2reg   = 1'b0;
        i_memWrite  = 1'b0;
        i_regWrite  = 1'b0;
        i_width     = 2'b00;
        i_sign_flag = 1'b0;
        i_result    = '0;
        i_data4Mem  = '0;
        i_write_reg = '0;
    endtask

    // Caller has presented a memory op; ack comes after 'gap' BUSY cycles. Counts stall cycles.
    task automatic mem_txn(input int gap, input logic [31:0] rdata, output int n);
        n = 0;
        #1 if (o_stall) n++;
        tick();
        idle_in();
        for (int i = 0; i < gap; i++) begin
            #1 if (o_stall) n++;
            tick();
        end
        i_dmem_rdata = rdata;
        i_dmem_ack   = 1'b1;
        #1 if (o_stall) n++;
        tick();
        i_dmem_ack   = 1'b0;
        i_dmem_rdata = '0;
        tick();
    endtask

    initial begin
        i_reset = 1'b0;
        i_step = 1'b0;
        i_dmem_ack = 1'b0;
        i_dmem_rdata = '0;
        idle_in();
        repeat (2) @(posedge clk);
        #2;
        chk("rst_stall", {31'b0, o_stall}, 0);
        chk("rst_req", {31'b0, o_dmem_req}, 0);
        chk("rst_regwrite", {31'b0, o_regWrite}, 0);
        chk("rst_wb_data", o_wb_data, 0);
        chk("rst_misaligned", {31'b0, o_misaligned}, 0);
        i_reset = 1'b1;
        tick();

        // ALU op passes straight through with latency 1.
        i_regWrite = 1'b1; i_result = 32'h1234; i_write_reg = 5'd7;
        #1 chk("alu_stall", {31'b0, o_stall}, 0);
        tick();
        idle_in();
        #1;
        chk("alu_wb_data", o_wb_data, 32'h1234);
        chk("alu_write_reg", {27'b0, o_write_reg}, 7);
        chk("alu_regwrite", {31'b0, o_regWrite}, 1);
        chk("alu_req", {31'b0, o_dmem_req}, 0);

        // Signed byte load at 0x103, ack after 3 BUSY cycles.
        i_mem2reg = 1'b1; i_regWrite = 1'b1; i_width = 2'b00; i_sign_flag = 1'b1;
        i_result = 32'h103; i_write_reg = 5'd5;
        push(K_REQ, 32'h100, 32'h8, 0, 0);
        push(K_WB, 1, 1, 32'hFFFF_FF80, 5);
        mem_txn(3, 32'h80FF_FF12, stalls);
        chk("lb_stall_cycles", stalls, 4);

        // Same load zero-extended, ack in the first BUSY cycle.
        i_mem2reg = 1'b1; i_regWrite = 1'b1; i_width = 2'b00; i_sign_flag = 1'b0;
        i_result = 32'h103; i_write_reg = 5'd5;
        push(K_REQ, 32'h100, 32'h8, 0, 0);
        push(K_WB, 1, 1, 32'h0000_0080, 5);
        mem_txn(0, 32'h80FF_FF12, stalls);
        chk("lbu_stall_cycles", stalls, 1);

        // Half store at 0x22.
        i_memWrite = 1'b1; i_regWrite = 1'b0; i_width = 2'b01;
        i_result = 32'h22; i_data4Mem = 32'hDEAD_BEEF; i_write_reg = 5'd3;
        push(K_REQ, 32'h20, 32'hC, 1, 32'hBEEF_BEEF);
        push(K_WB, 0, 0, 0, 3);
        mem_txn(1, 32'h0, stalls);
        chk("sh_stall_cycles", stalls, 2);

        // ALU op so the following bubble is visible on o_regWrite.
        i_regWrite = 1'b1; i_result = 32'h55; i_write_reg = 5'd2;
        tick();
        idle_in();

        // Misaligned word load at 0x41.
        i_mem2reg = 1'b1; i_regWrite = 1'b1; i_width = 2'b10; i_result = 32'h41; i_write_reg = 5'd4;
        #1 chk("mis_stall", {31'b0, o_stall}, 0);
        push(K_MIS, 0, 0, 0, 0);
        tick();
        idle_in();
        #1;
        chk("mis_pulse", {31'b0, o_misaligned}, 1);
        chk("mis_bubble", {31'b0, o_regWrite}, 0);
        chk("mis_req", {31'b0, o_dmem_req}, 0);
        tick();
        #1 chk("mis_pulse_end", {31'b0, o_misaligned}, 0);

        // i_step raised during BUSY: transaction still completes, new op is then frozen out.
        i_mem2reg = 1'b1; i_regWrite = 1'b1; i_width = 2'b10; i_result = 32'h200; i_write_reg = 5'd9;
        push(K_REQ, 32'h200, 32'hF, 0, 0);
        push(K_WB, 1, 1, 32'hCAFE_F00D, 9);
        tick();
        idle_in();
        i_step = 1'b1;
        #1 chk("step_busy_stall", {31'b0, o_stall}, 1);
        tick();
        i_dmem_ack = 1'b1; i_dmem_rdata = 32'hCAFE_F00D;
        #1 chk("step_ack_stall", {31'b0, o_stall}, 0);
        tick();
        i_dmem_ack = 1'b0; i_dmem_rdata = '0;
        i_mem2reg = 1'b1; i_regWrite = 1'b1; i_width = 2'b10; i_result = 32'h300; i_write_reg = 5'd12;
        #1 chk("step_new_stall", {31'b0, o_stall}, 0);
        tick();
        #1;
        chk("step_no_req", {31'b0, o_dmem_req}, 0);
        chk("step_wb_hold", {27'b0, o_write_reg}, 9);
        tick();
        #1 chk("step_no_req2", {31'b0, o_dmem_req}, 0);
        i_step = 1'b0;
        idle_in();
        tick();

        // Reset while BUSY aborts; a later ack is ignored.
        i_mem2reg = 1'b1; i_regWrite = 1'b1; i_width = 2'b10; i_result = 32'h104; i_write_reg = 5'd6;
        push(K_REQ, 32'h104, 32'hF, 0, 0);
        tick();
        idle_in();
        #1 chk("rb_req_high", {31'b0, o_dmem_req}, 1);
        @(negedge clk);
        #1 i_reset = 1'b0;
        #1;
        chk("rb_req", {31'b0, o_dmem_req}, 0);
        chk("rb_stall", {31'b0, o_stall}, 0);
        chk("rb_be", {28'b0, o_dmem_be}, 0);
        chk("rb_addr", o_dmem_addr, 0);
        chk("rb_wb_data", o_wb_data, 0);
        chk("rb_write_reg", {27'b0, o_write_reg}, 0);
        tick();
        i_reset = 1'b1;
        i_dmem_ack = 1'b1; i_dmem_rdata = 32'h0000_FFFF;
        #1 chk("rb_ack_stall", {31'b0, o_stall}, 0);
        tick();
        i_dmem_ack = 1'b0; i_dmem_rdata = '0;
        #1;
        chk("rb_ack_req", {31'b0, o_dmem_req}, 0);
        chk("rb_ack_regwrite", {31'b0, o_regWrite}, 0);
        i_regWrite = 1'b1; i_result = 32'hABC; i_write_reg = 5'd1;
        tick();
        idle_in();
        #1 chk("rb_idle_alu", o_wb_data, 32'hABC);

        repeat (2) tick();
        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
